// File: rtl/pixel_loader_pkg.sv
// Shared types and defaults for the pixel loader that feeds the network input frame.
package pixel_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } loader_state_t;

  localparam int DEFAULT_PIX_W     = 8;
  localparam int DEFAULT_THRESHOLD = 128;

endpackage

// File: rtl/pixel_loader.sv
// Binarizes a stream of grayscale bytes into a HEIGHT-bit shadow frame and
// commits it atomically to pixels once the frame length is confirmed.
module pixel_loader
  import pixel_loader_pkg::*;
#(
  parameter int HEIGHT    = 7,
  parameter int PIX_W     = DEFAULT_PIX_W,
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              err_clr,
  output logic [HEIGHT-1:0] pixels,
  output logic              frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HEIGHT - 1);

  // Unsigned compare widened by one bit so THRESHOLD == 2**PIX_W stays meaningful.
  function automatic logic binarize(input logic [PIX_W-1:0] d);
    return {1'b0, d} >= (PIX_W + 1)'(THRESHOLD);
  endfunction

  loader_state_t     state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic [HEIGHT-1:0] shadow;
  logic              accept;
  logic              wr_en;
  logic              err_set;
  logic              commit;

  assign in_ready = rst & (state != COMMIT);
  assign accept   = in_valid & in_ready;
  assign wr_idx   = (state == IDLE) ? '0 : idx;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          idx_nxt = IDX_W'(1);
          if (in_last) begin
            if (HEIGHT == 1) begin
              state_nxt = COMMIT;
            end else begin
              err_set = 1'b1;
              idx_nxt = '0;
            end
          end else begin
            state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = in_last ? COMMIT : DRAIN;
          end else if (in_last) begin
            err_set   = 1'b1;
            idx_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        // Overlong frame: swallow beats up to and including the last one.
        if (accept && in_last) begin
          err_set   = 1'b1;
          idx_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control: state, index, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (err_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Data: shadow assembly and committed outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow      <= '0;
      pixels      <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= commit;
      if (wr_en) begin
        shadow[wr_idx] <= binarize(in_data);
      end
      if (commit) begin
        pixels      <= shadow;
        frame_count <= frame_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// Directed bench for pixel_loader: framing, thresholds, length errors, backpressure, async reset.
module tb_pixel_loader;

  localparam int HEIGHT = 7;
  localparam int PIX_W  = 8;
  localparam int CNT_W  = 16;

  typedef logic [7:0] beat_arr_t [0:8];

  logic              clk;
  logic              rst;
  logic [PIX_W-1:0]  in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              err_clr;
  logic [HEIGHT-1:0] pixels;
  logic              frame_done;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_count;

  int checks;
  int errors;

  pixel_loader #(
    .HEIGHT(HEIGHT), .PIX_W(PIX_W), .THRESHOLD(128), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .err_clr(err_clr),
    .pixels(pixels), .frame_done(frame_done), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // Present one beat at a negedge and return just after the edge that accepts it.
  task automatic send_beat(input logic [7:0] d, input logic l);
    int   waitc;
    logic rdy;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    waitc    = 0;
    forever begin
      rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      waitc++;
      if (waitc > 20) begin
        checks++;
        errors++;
        $display("FAIL beat_accept timeout data=%0d", d);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 'x;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input beat_arr_t b, input int n, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        for (int g = 0; g < (k % 3); g++) idle_cycle();
      end
      send_beat(b[k], (k == n - 1));
    end
  endtask

  // Called right after the edge accepting a frame's last beat.
  task automatic expect_commit(input logic [HEIGHT-1:0] exp_pix, input logic [CNT_W-1:0] exp_cnt);
    idle_cycle();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL commit_in_ready got=%b exp=0", in_ready);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL done_early got=%b exp=0", frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL done_pulse got=%b exp=1", frame_done);
    end
    checks++;
    if (pixels !== exp_pix) begin
      errors++; $display("FAIL pixels got=%b exp=%b", pixels, exp_pix);
    end
    checks++;
    if (frame_count !== exp_cnt) begin
      errors++; $display("FAIL frame_count got=%0d exp=%0d", frame_count, exp_cnt);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL done_width got=%b exp=0", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pixels !== 7'b0 || frame_done !== 1'b0 || frame_err !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs pix=%b done=%b err=%b cnt=%0d exp all 0", pixels, frame_done, frame_err, frame_count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic();
    send_frame('{8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0}, 7, 1'b0);
    expect_commit(7'b0101010, 16'd1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL basic_err got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_boundary();
    send_frame('{8'd127, 8'd128, 8'd255, 8'd0, 8'd128, 8'd127, 8'd1, 8'd0, 8'd0}, 7, 1'b0);
    expect_commit(7'b0010110, 16'd2);
  endtask

  task automatic test_short_frame();
    send_frame('{8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd200, 8'd0, 8'd0, 8'd0}, 7, 1'b0);
    expect_commit(7'b0101010, 16'd3);
    send_frame('{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 4, 1'b0);
    idle_cycle();
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL short_err got=%b exp=1", frame_err);
    end
    @(negedge clk);
    checks++;
    if (pixels !== 7'b0101010 || frame_count !== 16'd3 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL short_hold pix=%b cnt=%0d done=%b exp pix=0101010 cnt=3 done=0", pixels, frame_count, frame_done);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL err_clr got=%b exp=0", frame_err);
    end
  endtask

  task automatic test_long_frame();
    for (int k = 0; k < 8; k++) send_beat(8'd255, 1'b0);
    // err_clr coincides with the error on the final drained beat; the error must win.
    err_clr = 1'b1;
    send_beat(8'd255, 1'b1);
    idle_cycle();
    err_clr = 1'b0;
    checks++;
    if (frame_err !== 1'b1) begin
      errors++; $display("FAIL long_err_wins got=%b exp=1", frame_err);
    end
    checks++;
    if (pixels !== 7'b0101010 || frame_count !== 16'd3 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL long_hold pix=%b cnt=%0d done=%b exp pix=0101010 cnt=3 done=0", pixels, frame_count, frame_done);
    end
    send_frame('{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0}, 7, 1'b0);
    expect_commit(7'h7F, 16'd4);
  endtask

  task automatic test_backpressure();
    send_frame('{8'd200, 8'd0, 8'd200, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0}, 7, 1'b1);
    // Offer the next frame's first beat while the loader sits in COMMIT.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd255; in_last = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_commit_ready got=%b exp=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || pixels !== 7'b1001101 || frame_count !== 16'd5) begin
      errors++;
      $display("FAIL bp_commit done=%b pix=%b cnt=%0d exp done=1 pix=1001101 cnt=5", frame_done, pixels, frame_count);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_held_ready got=%b exp=1", in_ready);
    end
    @(posedge clk);
    send_frame('{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0}, 6, 1'b1);
    expect_commit(7'b1010101, 16'd6);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 3; k++) send_beat(8'd200, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (pixels !== 7'b0 || frame_count !== 16'd0 || frame_err !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset pix=%b cnt=%0d err=%b done=%b rdy=%b exp all 0", pixels, frame_count, frame_err, frame_done, in_ready);
    end
    idle_cycle();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send_frame('{8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd0, 8'd0}, 7, 1'b0);
    expect_commit(7'h7F, 16'd1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++; $display("FAIL post_reset_err got=%b exp=0", frame_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_short_frame();
    test_long_frame();
    test_backpressure();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
